// File: rtl/simple_memory_pkg.sv
// Shared types and helpers for the simple_memory_be_init RAM family.
// Build option: SIMPLE_MEMORY_OUTREG_EN (see simple_memory_be_init.sv).
package simple_memory_pkg;

  localparam int BYTE_W = 8;

  // Same-address read-during-write behaviour.
  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  // Post-reset sequencing: zero-fill first, then serve traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // One byte of a byte-enable merge: new data where enabled, old data elsewhere.
  function automatic logic [BYTE_W-1:0] merge_byte(input logic [BYTE_W-1:0] old_byte,
                                                   input logic [BYTE_W-1:0] new_byte,
                                                   input logic              en);
    return en ? new_byte : old_byte;
  endfunction

  // True when an address names a real word; matters when DEPTH is not a power of two.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/simple_memory_lane.sv
// One byte lane of the RAM: DEPTH x 8 storage, synchronous write, combinational read.
// Out-of-range addresses are ignored on write and read back as zero.
module simple_memory_lane
  import simple_memory_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Byte storage write.
  // NOTE: the array has no reset branch on purpose; a reset on every word would turn the RAM
  // into flops. Known contents come from the clear sweep in the top instead.
  always_ff @(posedge clk) begin
    if (we && addr_ok(32'(waddr), DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous array read, guarded against addresses past the last word.
  always_comb begin
    rdata = '0;
    if (addr_ok(32'(raddr), DEPTH)) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/simple_memory_be_init.sv
// Simple-dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour and a zero-fill sweep after every reset.
// Build option: define SIMPLE_MEMORY_OUTREG_EN to add an output register (read latency 2).
module simple_memory_be_init
  import simple_memory_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ready,
  input  logic                       we,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid
);

  localparam int                NUM_BYTES = DATA_W / BYTE_W;
  localparam rdw_mode_e         RDW       = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                clr_en;
  logic                wr_en, rd_en;
  logic                bypass_hit;
  logic [NUM_BYTES-1:0] lane_we;
  logic [ADDR_W-1:0]   lane_waddr;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   mem_word;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;

  // Sweep state register; reset restarts the clear at word 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep next-state: one zero write per cycle, READY after the last word.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  assign ready = (state_q == READY);
  assign wr_en = ready & we;
  assign rd_en = ready & re;

  // The sweep owns the write port until it finishes; user writes are discarded meanwhile.
  assign lane_waddr = clr_en ? ptr_q : waddr;
  assign lane_wdata = clr_en ? '0 : wdata;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    assign lane_we[i] = clr_en | (wr_en & be[i]);

    simple_memory_lane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (lane_waddr),
      .wdata (lane_wdata[i*BYTE_W +: BYTE_W]),
      .raddr (raddr),
      .rdata (mem_word[i*BYTE_W +: BYTE_W])
    );
  end

  // A same-address write only shows through in WRITE_FIRST mode, and never for a dropped address.
  assign bypass_hit = (RDW == WRITE_FIRST) && wr_en && (waddr == raddr)
                      && addr_ok(32'(raddr), DEPTH);

  // Read word: stored word, with enabled bytes replaced by wdata on a bypass hit.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      rd_word[i*BYTE_W +: BYTE_W] = merge_byte(mem_word[i*BYTE_W +: BYTE_W],
                                               wdata[i*BYTE_W +: BYTE_W],
                                               bypass_hit & be[i]);
    end
  end

  // Read register: capture on an accepted read, hold otherwise; rvalid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_word;
      end
    end
  end

`ifdef SIMPLE_MEMORY_OUTREG_EN
  logic [DATA_W-1:0] rdata_q2;
  logic              rvalid_q2;

  // Output register: delays data and valid together by one more cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q2  <= '0;
      rvalid_q2 <= 1'b0;
    end else begin
      rvalid_q2 <= rvalid_q;
      if (rvalid_q) begin
        rdata_q2 <= rdata_q;
      end
    end
  end

  assign rdata  = rdata_q2;
  assign rvalid = rvalid_q2;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_simple_memory_be_init.sv
// Directed bench for simple_memory_be_init. Two instances share stimulus:
//   dut_a: DEPTH=16, READ_FIRST   dut_b: DEPTH=12, WRITE_FIRST
// Read latency follows SIMPLE_MEMORY_OUTREG_EN.
module tb_simple_memory_be_init;

`ifdef SIMPLE_MEMORY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [3:0]  raddr = '0;

  logic        ready_a, rvalid_a, ready_b, rvalid_b;
  logic [31:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  simple_memory_be_init #(.DATA_W(32), .DEPTH(16), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a), .we(we), .be(be), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
  );

  simple_memory_be_init #(.DATA_W(32), .DEPTH(12), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .we(we), .be(be), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] en, input logic [31:0] d);
    we = 1'b1; waddr = a; be = en; wdata = d;
    step();
    we = 1'b0; be = '0;
  endtask

  // Leaves the bench at the cycle where the read result should be visible.
  task automatic do_read(input logic [3:0] a);
    re = 1'b1; raddr = a;
    step();
    re = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic wait_ready(output int ca, output int cb);
    ca = -1; cb = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ready_a === 1'b1 && ca < 0) ca = c;
      if (ready_b === 1'b1 && cb < 0) cb = c;
      if (ca >= 0 && cb >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({ready_a, rvalid_a, rdata_a} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_a: got ready=%b rvalid=%b rdata=%h expected all 0", ready_a, rvalid_a, rdata_a);
    end
    n_checks++;
    if ({ready_b, rvalid_b, rdata_b} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_b: got ready=%b rvalid=%b rdata=%h expected all 0", ready_b, rvalid_b, rdata_b);
    end
  endtask

  task automatic test_sweep_timing();
    int ca, cb;
    rst_n = 1'b1;
    wait_ready(ca, cb);
    n_checks++;
    if (ca != 16) begin
      n_fail++;
      $display("FAIL sweep_len_a: got %0d cycles expected 16", ca);
    end
    n_checks++;
    if (cb != 12) begin
      n_fail++;
      $display("FAIL sweep_len_b: got %0d cycles expected 12", cb);
    end
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      n_checks++;
      if ({rvalid_a, rdata_a} !== {1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL clear_a[%0d]: got rvalid=%b rdata=%h expected 1/00000000", a, rvalid_a, rdata_a);
      end
      n_checks++;
      if ({rvalid_b, rdata_b} !== {1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL clear_b[%0d]: got rvalid=%b rdata=%h expected 1/00000000", a, rvalid_b, rdata_b);
      end
    end
    step();
    n_checks++;
    if ({rvalid_a, rvalid_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_rvalid_pulse: got %b%b expected 00", rvalid_a, rvalid_b);
    end
  endtask

  task automatic test_write_read();
    do_write(4'd3, 4'b1111, 32'hDEADBEEF);
    do_read(4'd3);
    n_checks++;
    if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL full_write: got a=%b/%h b=%b/%h expected 1/deadbeef", rvalid_a, rdata_a, rvalid_b, rdata_b);
    end
    step();
    n_checks++;
    if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_hold: got a=%b/%h b=%b/%h expected 0/deadbeef", rvalid_a, rdata_a, rvalid_b, rdata_b);
    end
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 4'b0101, 32'h11223344);
    do_read(4'd3);
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'hDE22BE44, 32'hDE22BE44}) begin
      n_fail++;
      $display("FAIL be_0101: got a=%h b=%h expected de22be44", rdata_a, rdata_b);
    end
    do_write(4'd3, 4'b0000, 32'hFFFFFFFF);
    do_read(4'd3);
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'hDE22BE44, 32'hDE22BE44}) begin
      n_fail++;
      $display("FAIL be_none: got a=%h b=%h expected de22be44", rdata_a, rdata_b);
    end
    do_write(4'd3, 4'b1000, 32'h77000000);
    do_read(4'd3);
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'h7722BE44, 32'h7722BE44}) begin
      n_fail++;
      $display("FAIL be_1000: got a=%h b=%h expected 7722be44", rdata_a, rdata_b);
    end
  endtask

  task automatic test_rdw();
    // Full-word same-address collision on a zeroed word.
    we = 1'b1; waddr = 4'd5; be = 4'b1111; wdata = 32'hA5A5A5A5; re = 1'b1; raddr = 4'd5;
    step();
    we = 1'b0; re = 1'b0; be = '0;
    repeat (LAT - 1) step();
    n_checks++;
    if ({rvalid_a, rdata_a} !== {1'b1, 32'h00000000}) begin
      n_fail++;
      $display("FAIL rdw_full_a: got %b/%h expected 1/00000000", rvalid_a, rdata_a);
    end
    n_checks++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL rdw_full_b: got %b/%h expected 1/a5a5a5a5", rvalid_b, rdata_b);
    end
    do_read(4'd5);
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL rdw_after: got a=%h b=%h expected a5a5a5a5", rdata_a, rdata_b);
    end
    // Partial-byte collision: WRITE_FIRST must merge.
    we = 1'b1; waddr = 4'd5; be = 4'b0011; wdata = 32'h12345678; re = 1'b1; raddr = 4'd5;
    step();
    we = 1'b0; re = 1'b0; be = '0;
    repeat (LAT - 1) step();
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'hA5A5A5A5, 32'hA5A55678}) begin
      n_fail++;
      $display("FAIL rdw_partial: got a=%h b=%h expected a5a5a5a5/a5a55678", rdata_a, rdata_b);
    end
    // Different addresses in the same cycle are independent.
    we = 1'b1; waddr = 4'd6; be = 4'b1111; wdata = 32'h01020304; re = 1'b1; raddr = 4'd3;
    step();
    we = 1'b0; re = 1'b0; be = '0;
    repeat (LAT - 1) step();
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'h7722BE44, 32'h7722BE44}) begin
      n_fail++;
      $display("FAIL rdw_diff_addr: got a=%h b=%h expected 7722be44", rdata_a, rdata_b);
    end
    do_read(4'd6);
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'h01020304, 32'h01020304}) begin
      n_fail++;
      $display("FAIL rdw_diff_write: got a=%h b=%h expected 01020304", rdata_a, rdata_b);
    end
  endtask

  task automatic test_out_of_range();
    do_write(4'd13, 4'b1111, 32'hCAFEF00D);
    do_read(4'd13);
    n_checks++;
    if ({rvalid_a, rdata_a} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL oor_a: got %b/%h expected 1/cafef00d", rvalid_a, rdata_a);
    end
    n_checks++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL oor_b: got %b/%h expected 1/00000000", rvalid_b, rdata_b);
    end
    do_read(4'd1);
    n_checks++;
    if ({rdata_a, rdata_b} !== 64'h0) begin
      n_fail++;
      $display("FAIL oor_alias: got a=%h b=%h expected 00000000", rdata_a, rdata_b);
    end
    // Same-cycle collision on a dropped address must not bypass.
    we = 1'b1; waddr = 4'd13; be = 4'b1111; wdata = 32'hFFFFFFFF; re = 1'b1; raddr = 4'd13;
    step();
    we = 1'b0; re = 1'b0; be = '0;
    repeat (LAT - 1) step();
    n_checks++;
    if ({rdata_a, rdata_b} !== {32'hCAFEF00D, 32'h0}) begin
      n_fail++;
      $display("FAIL oor_rdw: got a=%h b=%h expected cafef00d/00000000", rdata_a, rdata_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [2];
    int idx;
    exp_w[0] = 32'h7722BE44;
    exp_w[1] = 32'h01020304;
    repeat (3) step();
    for (int k = 0; k < LAT + 2; k++) begin
      if (k < 2) begin
        re = 1'b1;
        raddr = (k == 0) ? 4'd3 : 4'd6;
      end else begin
        re = 1'b0;
      end
      step();
      idx = k + 1 - LAT;
      n_checks++;
      if (idx >= 0 && idx < 2) begin
        if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {1'b1, exp_w[idx], 1'b1, exp_w[idx]}) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got a=%b/%h b=%b/%h expected 1/%h", k, rvalid_a, rdata_a,
                   rvalid_b, rdata_b, exp_w[idx]);
        end
      end else if ({rvalid_a, rvalid_b} !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_idle[%0d]: got rvalid=%b%b expected 00", k, rvalid_a, rvalid_b);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_midsweep_reset();
    int ca, cb;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready_a, ready_b, rvalid_a, rvalid_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midsweep_rst: got ready=%b%b rvalid=%b%b expected 0000", ready_a, ready_b,
               rvalid_a, rvalid_b);
    end
    step();
    we = 1'b1; waddr = 4'd0; be = 4'b1111; wdata = 32'hFFFFFFFF; re = 1'b1; raddr = 4'd0;
    rst_n = 1'b1;
    ca = -1; cb = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c <= 10) begin
        n_checks++;
        if ({rvalid_a, rvalid_b} !== 2'b00) begin
          n_fail++;
          $display("FAIL sweep_rvalid[%0d]: got %b%b expected 00", c, rvalid_a, rvalid_b);
        end
        if (c == 10) begin
          we = 1'b0; re = 1'b0; be = '0;
        end
      end
      if (ready_a === 1'b1 && ca < 0) ca = c;
      if (ready_b === 1'b1 && cb < 0) cb = c;
      if (ca >= 0 && cb >= 0) break;
    end
    n_checks++;
    if (ca != 16 || cb != 12) begin
      n_fail++;
      $display("FAIL resweep_len: got a=%0d b=%0d expected 16/12", ca, cb);
    end
    do_read(4'd0);
    n_checks++;
    if ({rdata_a, rdata_b} !== 64'h0) begin
      n_fail++;
      $display("FAIL sweep_write_dropped: got a=%h b=%h expected 00000000", rdata_a, rdata_b);
    end
    do_read(4'd13);
    n_checks++;
    if (rdata_a !== 32'h0) begin
      n_fail++;
      $display("FAIL resweep_clear_a13: got %h expected 00000000", rdata_a);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_timing();
    test_clear_readback();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_midsweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
